// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard control: load-use/RAW stalls, EX operand forwarding and a multi-cycle mul/div tracker.
// Define HAZ_FORWARD_EN to forward from EX/MEM and MEM/WB; otherwise any pending register write stalls ID.
module pipeline_hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_reads_hilo,
  input  logic       id_md_start,
  input  logic       id_md_div,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic       ex_we,
  input  logic       ex_load,
  input  logic [4:0] ex_rd,
  input  logic       mem_we,
  input  logic [4:0] mem_rd,
  input  logic       wb_we,
  input  logic [4:0] wb_rd,
  output logic       pc_le,
  output logic       ifid_le,
  output logic       cmux,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       md_busy,
  output logic       hilo_we
);

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_t;

  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

  md_state_t  state;
  logic [5:0] cnt;
  logic       stall;
  logic       load_use;
  logic       raw_stall;
  logic       md_hazard;

  // Register 0 is hardwired, so a zero destination can never create a dependency.
  function automatic logic id_dep(input logic we, input logic [4:0] rd, input logic [4:0] rs,
                                  input logic uses_rs, input logic [4:0] rt, input logic uses_rt);
    return we && (rd != 5'd0) && ((uses_rs && rd == rs) || (uses_rt && rd == rt));
  endfunction

  function automatic logic src_match(input logic we, input logic [4:0] rd, input logic [4:0] src);
    return we && (rd != 5'd0) && (rd == src);
  endfunction

  assign load_use  = ex_load && id_dep(ex_we, ex_rd, id_rs, id_uses_rs, id_rt, id_uses_rt);
  assign md_hazard = md_busy && (id_reads_hilo || id_md_start);

`ifdef HAZ_FORWARD_EN
  logic unused_ok;
  assign unused_ok = ^{wb_we, wb_rd};
  assign raw_stall = load_use;

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!reset) begin
      if (src_match(ex_we, ex_rd, ex_rs))        fwd_a = 2'b01;
      else if (src_match(mem_we, mem_rd, ex_rs)) fwd_a = 2'b10;
      if (src_match(ex_we, ex_rd, ex_rt))        fwd_b = 2'b01;
      else if (src_match(mem_we, mem_rd, ex_rt)) fwd_b = 2'b10;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{ex_rs, ex_rt};
  assign fwd_a     = 2'b00;
  assign fwd_b     = 2'b00;
  // Without forwarding, ID waits until every in-flight writer has retired.
  assign raw_stall = load_use
                   || id_dep(ex_we,  ex_rd,  id_rs, id_uses_rs, id_rt, id_uses_rt)
                   || id_dep(mem_we, mem_rd, id_rs, id_uses_rs, id_rt, id_uses_rt)
                   || id_dep(wb_we,  wb_rd,  id_rs, id_uses_rs, id_rt, id_uses_rt);
`endif

  assign stall   = raw_stall || md_hazard;
  assign pc_le   = !stall;
  assign ifid_le = !stall;
  assign cmux    = !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= MD_IDLE;
      cnt     <= 6'd0;
      md_busy <= 1'b0;
      hilo_we <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          hilo_we <= 1'b0;
          if (id_md_start && !stall) begin
            state   <= MD_BUSY;
            cnt     <= id_md_div ? DIV_LOAD : MULT_LOAD;
            md_busy <= 1'b1;
          end
        end
        MD_BUSY: begin
          if (cnt == 6'd0) begin
            state   <= MD_DONE;
            hilo_we <= 1'b1;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        MD_DONE: begin
          state   <= MD_IDLE;
          md_busy <= 1'b0;
          hilo_we <= 1'b0;
        end
        default: begin
          state   <= MD_IDLE;
          cnt     <= 6'd0;
          md_busy <= 1'b0;
          hilo_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with default MULT_CYCLES=4, DIV_CYCLES=32.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs, id_uses_rt, id_reads_hilo, id_md_start, id_md_div;
  logic       ex_we, ex_load, mem_we, wb_we;
  logic       pc_le, ifid_le, cmux, md_busy, hilo_we;
  logic [1:0] fwd_a, fwd_b;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reads_hilo(id_reads_hilo), .id_md_start(id_md_start), .id_md_div(id_md_div),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_we(ex_we), .ex_load(ex_load), .ex_rd(ex_rd),
    .mem_we(mem_we), .mem_rd(mem_rd), .wb_we(wb_we), .wb_rd(wb_rd),
    .pc_le(pc_le), .ifid_le(ifid_le), .cmux(cmux), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .md_busy(md_busy), .hilo_we(hilo_we)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_reads_hilo = 0; id_md_start = 0; id_md_div = 0;
    ex_rs = 0; ex_rt = 0; ex_we = 0; ex_load = 0; ex_rd = 0;
    mem_we = 0; mem_rd = 0; wb_we = 0; wb_rd = 0;
  endtask

  task automatic check_le(input string tag, input logic exp);
    check({tag, "_pc_le"},   pc_le,   exp);
    check({tag, "_ifid_le"}, ifid_le, exp);
    check({tag, "_cmux"},    cmux,    exp);
  endtask

  initial begin
    int cnt;
    int pulses;
    clear_inputs();
    reset = 1'b1;
    #12;
    check("rst_md_busy", md_busy, 0);
    check("rst_hilo_we", hilo_we, 0);
    check("rst_fwd_a", fwd_a, 0);
    check("rst_fwd_b", fwd_b, 0);
    check_le("rst", 1);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Load-use: one stalled cycle, then the pipeline moves on.
    ex_load = 1; ex_we = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
    #1 check_le("lu", 0);
    tick();
    clear_inputs();
    #1 check_le("lu_after", 1);

    // Register 0 never creates a hazard.
    ex_load = 1; ex_we = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1;
    #1 check("r0_pc_le", pc_le, 1);
    clear_inputs();

    // Match without the uses flag is not a hazard.
    ex_load = 1; ex_we = 1; ex_rd = 9; id_rt = 9; id_uses_rt = 0;
    #1 check("nouse_pc_le", pc_le, 1);
    id_uses_rt = 1;
    #1 check("rt_lu_pc_le", pc_le, 0);
    clear_inputs();

    // MEM-stage writer: stalls only without forwarding.
    mem_we = 1; mem_rd = 7; id_rt = 7; id_uses_rt = 1;
`ifdef HAZ_FORWARD_EN
    #1 check("mem_dep_pc_le", pc_le, 1);
`else
    #1 check("mem_dep_pc_le", pc_le, 0);
`endif
    clear_inputs();
    wb_we = 1; wb_rd = 12; id_rs = 12; id_uses_rs = 1;
`ifdef HAZ_FORWARD_EN
    #1 check("wb_dep_pc_le", pc_le, 1);
`else
    #1 check("wb_dep_pc_le", pc_le, 0);
`endif
    clear_inputs();

    // Forward priority EX/MEM over MEM/WB.
    ex_we = 1; ex_rd = 3; mem_we = 1; mem_rd = 3; ex_rs = 3; mem_rd = 3; ex_rt = 4;
`ifdef HAZ_FORWARD_EN
    #1 check("fwd_a_ex", fwd_a, 2'b01);
`else
    #1 check("fwd_a_ex", fwd_a, 2'b00);
`endif
    check("fwd_pc_le", pc_le, 1);
    ex_we = 0; mem_rd = 4;
`ifdef HAZ_FORWARD_EN
    #1 check("fwd_b_mem", fwd_b, 2'b10);
`else
    #1 check("fwd_b_mem", fwd_b, 2'b00);
`endif
    clear_inputs();

    // MULT: md_busy for 4 busy + 1 done cycles, hilo_we on the last.
    id_md_start = 1; id_md_div = 0;
    tick();
    clear_inputs();
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("mult_busy_c%0d", i), md_busy, 1);
      check($sformatf("mult_hilo_c%0d", i), hilo_we, (i == 5) ? 1 : 0);
      tick();
    end
    check("mult_idle_busy", md_busy, 0);
    check("mult_idle_hilo", hilo_we, 0);

    // Start under a load-use stall is held off until the stall clears.
    id_md_start = 1; ex_load = 1; ex_we = 1; ex_rd = 6; id_rs = 6; id_uses_rs = 1;
    tick();
    check("start_stalled", md_busy, 0);
    ex_load = 0; ex_we = 0;
    tick();
    id_md_start = 0;
    check("start_released", md_busy, 1);
    // Load-use plus mul/div hazard gives one combined stall.
    ex_load = 1; ex_we = 1; ex_rd = 6; id_reads_hilo = 1;
    #1 check_le("combined", 0);
    clear_inputs();
    cnt = 0;
    while (md_busy && cnt < 20) begin tick(); cnt++; end
    check("mult2_finish", md_busy, 0);

    // DIV then MFHI: stalled through 32 busy cycles and the done cycle.
    id_md_start = 1; id_md_div = 1;
    tick();
    id_md_start = 0; id_md_div = 0; id_reads_hilo = 1;
    cnt = 0;
    #1;
    while (!pc_le && cnt < 100) begin tick(); cnt++; end
    check("div_stall_cycles", cnt, 33);
    check("div_release_idle", md_busy, 0);
    clear_inputs();

    // Reset at counter=10 during DIV aborts with no hilo_we pulse.
    id_md_start = 1; id_md_div = 1;
    tick();
    clear_inputs();
    for (int i = 0; i < 21; i++) tick();
    check("div_mid_busy", md_busy, 1);
    #2 reset = 1'b1;
    #1 check("abort_md_busy", md_busy, 0);
    check("abort_hilo_we", hilo_we, 0);
    check("abort_pc_le", pc_le, 1);
    tick();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (hilo_we) pulses++;
    end
    check("abort_no_hilo", pulses, 0);
    check("abort_stay_idle", md_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
